// File: rtl/karatsuba_sum.sv
// karatsuba_sum
//   Final accumulation stage of a 32x32 Karatsuba multiplier. Takes the three
//   pre-shifted partial products and produces their W-bit sum in two adder
//   steps (mult1+mult2, then +mult3), with a carry-out flag.
//
//   Ports
//     clk        clock, rising edge
//     rst        asynchronous reset, active low
//     mult1      high partial product (already << 32)
//     mult2      cross-term partial product (already << 16)
//     mult3      low partial product
//     in_valid   operands valid
//     in_ready   block accepts operands this cycle (combinational)
//     out_data   registered sum, modulo 2^W
//     out_ovf    carry out of bit W-1 in either addition
//     out_valid  out_data/out_ovf valid
//     out_ready  downstream accepts the result
//     done_cnt   number of completed output handshakes, wraps at 16 bits
//
//   Sequence: IDLE -(in hs)-> SUM_A -> SUM_B -> DONE -(out hs)-> IDLE or SUM_A.
//   A result leaves every 3 cycles when both sides keep their valid/ready high.
module karatsuba_sum #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] mult1,
  input  logic [W-1:0] mult2,
  input  logic [W-1:0] mult3,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_ovf,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [15:0]  done_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SUM_A = 2'd1,
    SUM_B = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   m1_q, m2_q, m3_q;
  logic [W:0]     partial;
  logic [W:0]     sum_b;
  logic           in_hs, out_hs;

  // Handshake qualifiers. in_ready opens in DONE only when the current result
  // is leaving on the same edge, so a new operand set never overwrites it.
  always_comb begin
    out_valid = (state == DONE);
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    in_hs     = in_valid && in_ready;
    out_hs    = out_valid && out_ready;
  end

  // Second adder step: low W bits of the first sum plus the low product.
  assign sum_b = {1'b0, partial[W-1:0]} + {1'b0, m3_q};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (in_hs) state_nxt = SUM_A;
      SUM_A: state_nxt = SUM_B;
      SUM_B: state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = in_valid ? SUM_A : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------- datapath
  // All three operands are latched on the input handshake, so the upstream
  // bus is free to change while the sum is in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m1_q <= '0;
      m2_q <= '0;
      m3_q <= '0;
    end else if (in_hs) begin
      m1_q <= mult1;
      m2_q <= mult2;
      m3_q <= mult3;
    end
  end

  // First adder step keeps its carry in bit W so it can feed out_ovf later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 partial <= '0;
    else if (state == SUM_A)  partial <= {1'b0, m1_q} + {1'b0, m2_q};
  end

  // Result registers only load in SUM_B, which makes them hold through any
  // downstream stall in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else if (state == SUM_B) begin
      out_data <= sum_b[W-1:0];
      out_ovf  <= partial[W] | sum_b[W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        done_cnt <= '0;
    else if (out_hs) done_cnt <= done_cnt + 16'd1;
  end

endmodule

// File: tb/tb_karatsuba_sum.sv
// tb_karatsuba_sum
//   Randomized and directed stimulus for karatsuba_sum (W=64). A negedge
//   scoreboard predicts each result from the operand values seen at the input
//   handshake (plain 66-bit sum, overflow = sum >= 2^64), and for operand sets
//   built from a 32x32 Karatsuba split it also expects the true product.
module tb_karatsuba_sum;
  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  mult1 = '0, mult2 = '0, mult3 = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_ovf;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [15:0]   done_cnt;

  karatsuba_sum #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .mult1(mult1), .mult2(mult2), .mult3(mult3),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_valid(out_valid),
    .out_ready(out_ready), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic        o;
    int          cyc;
    logic        pv;
    logic [63:0] prod;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0, n_pass = 0, cyc = 0;
  logic [15:0] cnt_m = '0;
  logic        prev_ov = 1'b0;
  logic        cur_pv = 1'b0;
  logic [63:0] cur_prod = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] c, input int cy,
                                 input logic pv, input logic [63:0] pr);
    logic [65:0] t;
    exp_t e;
    t      = 66'(a) + 66'(b) + 66'(c);
    e.d    = t[63:0];
    e.o    = (t[65:64] != 2'b00);
    e.cyc  = cy;
    e.pv   = pv;
    e.prod = pr;
    return e;
  endfunction

  // Scoreboard: sampled on negedge, i.e. it sees what the next posedge will do.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst) begin
      q.delete();
      cnt_m   = '0;
      prev_ov = 1'b0;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_ready", 64'(in_ready),  64'd1);
      chk("rst_cnt",   64'(done_cnt),  64'd0);
      chk("rst_data",  out_data,       64'd0);
      chk("rst_ovf",   64'(out_ovf),   64'd0);
    end else begin
      chk("done_cnt", 64'(done_cnt), 64'(cnt_m));
      if (out_valid && !prev_ov) begin
        if (q.size() == 0) chk("stale_out", 64'd1, 64'd0);
        else               chk("latency", 64'(cyc - q[0].cyc), 64'd3);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexp_out", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk("sb_data", out_data, e.d);
          chk("sb_ovf", 64'(out_ovf), 64'(e.o));
          if (e.pv) begin
            chk("kara_prod", out_data, e.prod);
            chk("kara_ovf", 64'(out_ovf), 64'd0);
          end
          cnt_m = cnt_m + 16'd1;
        end
      end
      if (in_valid && in_ready) q.push_back(model(mult1, mult2, mult3, cyc, cur_pv, cur_prod));
      prev_ov = out_valid;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       input logic pv, input logic [63:0] pr);
    mult1 = a; mult2 = b; mult3 = c; cur_pv = pv; cur_prod = pr;
  endtask

  // 32x32 operands split into 16-bit halves; partials pre-shifted.
  task automatic drive_kara;
    logic [31:0] a, b;
    logic [63:0] z2, z1, z0;
    a  = $urandom;
    b  = $urandom;
    if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF;
    if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
    z2 = 64'(a[31:16]) * 64'(b[31:16]);
    z0 = 64'(a[15:0])  * 64'(b[15:0]);
    z1 = 64'(a[31:16]) * 64'(b[15:0]) + 64'(a[15:0]) * 64'(b[31:16]);
    drive(z2 << 32, z1 << 16, z0, 1'b1, 64'(a) * 64'(b));
  endtask

  task automatic drive_rand;
    case ($urandom_range(0, 3))
      0, 1: drive_kara();
      2: drive({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 64'd0);
      default: drive(~64'($urandom_range(0, 3)), 64'($urandom_range(0, 5)),
                     64'($urandom_range(0, 5)), 1'b0, 64'd0);
    endcase
  endtask

  // Call just after a posedge. Returns at the negedge where out_valid is seen.
  task automatic run_one(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic pv, input logic [63:0] pr,
                         input logic [63:0] exp_d, input logic exp_o,
                         input string tag, output int waits);
    int n;
    drive(a, b, c, pv, pr);
    in_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk({tag, "_hs_timeout"}, 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    step();
    in_valid = 1'b0;
    drive({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 64'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk({tag, "_lat"},  64'(n),       64'd3);
    chk({tag, "_data"}, out_data,     exp_d);
    chk({tag, "_ovf"},  64'(out_ovf), 64'(exp_o));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    logic [15:0] c0;

    repeat (3) @(negedge clk);
    step();
    // First handshake lands on the first edge after release.
    rst = 1'b1;
    out_ready = 1'b1;
    run_one(64'h0000_0003_0000_0000, 64'h0000_0000_000A_0000, 64'h8, 1'b0, 64'd0,
            64'h0000_0003_000A_0008, 1'b0, "basic", w);
    chk("first_hs_wait", 64'(w), 64'd0);
    step();

    run_one(64'hFFFE_0001_0000_0000, 64'h0001_FFFC_0002_0000, 64'h0000_0000_FFFE_0001,
            1'b1, 64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFE_0000_0001, 1'b0, "max32", w);
    step();

    run_one(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b0, 64'd0, 64'h0, 1'b1, "carry", w);
    step();

    // Downstream stall in DONE.
    out_ready = 1'b0;
    run_one(64'h0123_4567_89AB_CDEF, 64'h0000_0000_1111_0000, 64'h22, 1'b0, 64'd0,
            64'h0123_4567_9ABC_CE11, 1'b0, "stall", w);
    c0 = done_cnt;
    repeat (5) begin
      @(negedge clk);
      chk("hold_data",  out_data,        64'h0123_4567_9ABC_CE11);
      chk("hold_valid", 64'(out_valid),  64'd1);
      chk("hold_ready", 64'(in_ready),   64'd0);
      chk("hold_cnt",   64'(done_cnt),   64'(c0));
    end
    step();
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("stall_cnt_inc", 64'(done_cnt),  64'(c0 + 16'd1));
    chk("stall_release", 64'(out_valid), 64'd0);
    step();

    // Back-to-back: in_valid held, in_ready pulses once per 3 cycles.
    in_valid = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      drive_kara();
      @(negedge clk);
      chk("b2b_ready", 64'(in_ready),  64'((k % 3) == 0));
      chk("b2b_valid", 64'(out_valid), 64'(((k % 3) == 0) && (k > 0)));
      step();
    end
    in_valid = 1'b0;
    repeat (6) step();

    // Reset while an operand set sits in SUM_B.
    drive({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 64'd0);
    in_valid = 1'b1;
    @(negedge clk);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_cnt",   64'(done_cnt),  64'd0);
    chk("arst_ready", 64'(in_ready),  64'd1);
    chk("arst_data",  out_data,       64'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("no_stale", 64'(out_valid), 64'd0);
    end
    step();

    // Random traffic on both sides.
    for (int i = 0; i < 600; i++) begin
      drive_rand();
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) step();
    chk("drain", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
